// File: rtl/model_linear_controller_engine_pkg.sv
// Shared linear-controller definitions: default widths, control constants, FSM encoding.
package model_linear_controller_engine_pkg;

  localparam int DATA_SIZE    = 16;
  localparam int CONTROL_SIZE = 4;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  typedef enum logic [2:0] {
    STATE_IDLE       = 3'd0,
    STATE_LOAD_X     = 3'd1,
    STATE_LOAD_B     = 3'd2,
    STATE_ACCUMULATE = 3'd3,
    STATE_EMIT       = 3'd4
  } state_t;

endpackage

// File: rtl/model_linear_controller_engine_if.sv
// Stream interface of the linear controller: run control, x/b/W element strobes, result strobe.
interface model_linear_controller_engine_if #(
  parameter int DATA_SIZE    = model_linear_controller_engine_pkg::DATA_SIZE,
  parameter int CONTROL_SIZE = model_linear_controller_engine_pkg::CONTROL_SIZE
);

  logic                    start;
  logic [CONTROL_SIZE-1:0] size_x_in;
  logic [CONTROL_SIZE-1:0] size_l_in;
  logic                    x_in_enable;
  logic [DATA_SIZE-1:0]    x_in;
  logic                    b_in_enable;
  logic [DATA_SIZE-1:0]    b_in;
  logic                    w_in_enable;
  logic [DATA_SIZE-1:0]    w_in;
  logic                    h_out_enable;
  logic [DATA_SIZE-1:0]    h_out;
  logic                    ready;

  modport master (
    output start, size_x_in, size_l_in,
    output x_in_enable, x_in, b_in_enable, b_in, w_in_enable, w_in,
    input  h_out_enable, h_out, ready
  );

  modport slave (
    input  start, size_x_in, size_l_in,
    input  x_in_enable, x_in, b_in_enable, b_in, w_in_enable, w_in,
    output h_out_enable, h_out, ready
  );

endinterface

// File: rtl/model_linear_controller_engine_mac.sv
// Combinational multiply-add acc + w*x, product and sum wrapped to DATA_SIZE bits.
module model_linear_controller_mac #(
  parameter int DATA_SIZE = 16
) (
  input  logic signed [DATA_SIZE-1:0] acc_i,
  input  logic signed [DATA_SIZE-1:0] w_i,
  input  logic signed [DATA_SIZE-1:0] x_i,
  output logic signed [DATA_SIZE-1:0] sum_o
);

  logic signed [DATA_SIZE-1:0] prod;

  always_comb begin
    prod  = w_i * x_i;
    sum_o = acc_i + prod;
  end

endmodule

// File: rtl/model_linear_controller_engine.sv
// Streaming h = b + W*x engine: buffers x once, then per row takes one bias and SIZE_X weights.
module model_linear_controller_engine #(
  parameter int DATA_SIZE    = model_linear_controller_engine_pkg::DATA_SIZE,
  parameter int CONTROL_SIZE = model_linear_controller_engine_pkg::CONTROL_SIZE
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  model_linear_controller_engine_if.slave   eng_if
);

  import model_linear_controller_engine_pkg::*;

  localparam int DEPTH = 2 ** CONTROL_SIZE;

  typedef logic [CONTROL_SIZE-1:0] cnt_t;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  state_t               state_q, state_d;
  cnt_t                 size_x_q, size_l_q;
  cnt_t                 col_q, row_q;
  logic [DATA_SIZE-1:0] acc_q;
  logic [DATA_SIZE-1:0] h_out_q;
  logic                 zero_rdy_q;
  logic [DATA_SIZE-1:0] xbuf_q [DEPTH];
  logic [DATA_SIZE-1:0] mac_sum;

  logic start_acc, zero_size, x_acc, b_acc, w_acc, last_col, last_row;

  always_comb begin
    start_acc = (state_q == STATE_IDLE) && eng_if.start;
    zero_size = (eng_if.size_x_in == '0) || (eng_if.size_l_in == '0);
    x_acc     = (state_q == STATE_LOAD_X) && eng_if.x_in_enable;
    b_acc     = (state_q == STATE_LOAD_B) && eng_if.b_in_enable;
    w_acc     = (state_q == STATE_ACCUMULATE) && eng_if.w_in_enable;
    last_col  = (col_q == size_x_q - CNT_ONE);
    last_row  = (row_q == size_l_q - CNT_ONE);
  end

  model_linear_controller_mac #(
    .DATA_SIZE (DATA_SIZE)
  ) u_mac (
    .acc_i (acc_q),
    .w_i   (eng_if.w_in),
    .x_i   (xbuf_q[col_q]),
    .sum_o (mac_sum)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STATE_IDLE:       if (start_acc && !zero_size) state_d = STATE_LOAD_X;
      STATE_LOAD_X:     if (x_acc && last_col)       state_d = STATE_LOAD_B;
      STATE_LOAD_B:     if (b_acc)                   state_d = STATE_ACCUMULATE;
      STATE_ACCUMULATE: if (w_acc && last_col)       state_d = STATE_EMIT;
      STATE_EMIT:       state_d = last_row ? STATE_IDLE : STATE_LOAD_B;
      default:          state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      size_x_q   <= '0;
      size_l_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      acc_q      <= '0;
      h_out_q    <= '0;
      zero_rdy_q <= 1'b0;
    end else begin
      // a zero-length run never leaves IDLE; it only produces the READY pulse
      zero_rdy_q <= start_acc && zero_size;
      if (start_acc) begin
        size_x_q <= eng_if.size_x_in;
        size_l_q <= eng_if.size_l_in;
        col_q    <= '0;
        row_q    <= '0;
      end
      if (x_acc || w_acc) begin
        col_q <= last_col ? '0 : col_q + CNT_ONE;
      end
      if (b_acc) begin
        acc_q <= eng_if.b_in;
      end
      if (w_acc) begin
        acc_q <= mac_sum;
        if (last_col) h_out_q <= mac_sum;
      end
      if (state_q == STATE_EMIT) begin
        row_q <= last_row ? '0 : row_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (x_acc) begin
      xbuf_q[col_q] <= eng_if.x_in;
    end
  end

  always_comb begin
    eng_if.h_out        = h_out_q;
    eng_if.h_out_enable = ZERO;
    eng_if.ready        = zero_rdy_q;
    if (state_q == STATE_EMIT) begin
      eng_if.h_out_enable = ONE;
      if (last_row) eng_if.ready = ONE;
    end
  end

endmodule

// File: tb/tb_model_linear_controller_engine.sv
// Table-driven bench with an output scoreboard, plus hand sequences for zero size and reset.
module tb_model_linear_controller_engine;

  typedef struct {
    int                sx;
    int                sl;
    logic [3:0][15:0]  x;
    logic [3:0][15:0]  b;
    logic [15:0][15:0] w;
    logic [3:0][15:0]  h;
  } vec_t;

  typedef struct {
    logic [15:0] h;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  logic mon_en;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[4];

  model_linear_controller_engine_if #(.DATA_SIZE(16), .CONTROL_SIZE(4)) dif ();

  model_linear_controller_engine #(
    .DATA_SIZE    (16),
    .CONTROL_SIZE (4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .eng_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dif.start       = 1'b0;
    dif.x_in_enable = 1'b0;
    dif.b_in_enable = 1'b0;
    dif.w_in_enable = 1'b0;
  endtask

  function automatic logic [15:0] model_h(input vec_t v, input int l);
    logic [31:0] s;
    s = 32'(v.b[l]);
    for (int i = 0; i < v.sx; i++) s = s + v.w[l*v.sx+i] * v.x[i];
    return s[15:0];
  endfunction

  // Gap cycles: stall the current stream, toggle the others and a stray START.
  task automatic gap(input bit en, input int stream);
    if (en) begin
      repeat ($urandom_range(0, 2)) begin
        dif.start       = 1'($urandom_range(0, 1));
        dif.size_x_in   = 4'($urandom);
        dif.size_l_in   = 4'($urandom);
        dif.x_in_enable = (stream != 0) && ($urandom_range(0, 1) == 1);
        dif.b_in_enable = (stream != 1) && ($urandom_range(0, 1) == 1);
        dif.w_in_enable = (stream != 2) && ($urandom_range(0, 1) == 1);
        dif.x_in        = 16'($urandom);
        dif.b_in        = 16'($urandom);
        dif.w_in        = 16'($urandom);
        tick();
      end
      idle_inputs();
    end
  endtask

  task automatic run_vec(input vec_t v, input bit gaps);
    for (int l = 0; l < v.sl; l++) sb.push_back('{h: v.h[l], last: (l == v.sl - 1)});
    dif.size_x_in = 4'(v.sx);
    dif.size_l_in = 4'(v.sl);
    dif.start     = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < v.sx; i++) begin
      gap(gaps, 0);
      dif.x_in_enable = 1'b1;
      dif.x_in        = v.x[i];
      tick();
      dif.x_in_enable = 1'b0;
    end
    for (int l = 0; l < v.sl; l++) begin
      gap(gaps, 1);
      dif.b_in_enable = 1'b1;
      dif.b_in        = v.b[l];
      tick();
      dif.b_in_enable = 1'b0;
      for (int i = 0; i < v.sx; i++) begin
        gap(gaps, 2);
        dif.w_in_enable = 1'b1;
        dif.w_in        = v.w[l*v.sx+i];
        tick();
        dif.w_in_enable = 1'b0;
      end
      tick();
    end
    tick();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dif.h_out_enable) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_h_out: got %0h, required no output", dif.h_out);
        end else begin
          e = sb.pop_front();
          check("h_out", 32'(dif.h_out), 32'(e.h));
          check("ready_with_h_out", 32'(dif.ready), 32'(e.last));
        end
      end else if (dif.ready) begin
        n_vec++;
        n_err++;
        $display("FAIL ready_without_h_out: got 1, required 0");
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    idle_inputs();
    dif.size_x_in = '0;
    dif.size_l_in = '0;
    dif.x_in      = '0;
    dif.b_in      = '0;
    dif.w_in      = '0;

    tbl[0] = '{sx: 2, sl: 1, x: '0, b: '0, w: '0, h: '0};
    tbl[0].x[0] = 16'd3; tbl[0].x[1] = 16'd4;
    tbl[0].b[0] = 16'd5;
    tbl[0].w[0] = 16'd1; tbl[0].w[1] = 16'd2;
    tbl[0].h[0] = 16'd16;

    tbl[1] = '{sx: 3, sl: 2, x: '0, b: '0, w: '0, h: '0};
    tbl[1].x[0] = 16'd1; tbl[1].x[1] = 16'd2; tbl[1].x[2] = 16'd3;
    tbl[1].b[0] = 16'd0; tbl[1].b[1] = 16'd10;
    tbl[1].w[0] = 16'd1; tbl[1].w[1] = 16'd1; tbl[1].w[2] = 16'd1;
    tbl[1].w[3] = 16'd2; tbl[1].w[4] = 16'd0; tbl[1].w[5] = 16'hFFFF;
    tbl[1].h[0] = 16'd6; tbl[1].h[1] = 16'd9;

    tbl[2] = '{sx: 1, sl: 1, x: '0, b: '0, w: '0, h: '0};
    tbl[2].x[0] = 16'h4000; tbl[2].w[0] = 16'd4; tbl[2].b[0] = 16'd1;
    tbl[2].h[0] = 16'h0001;

    tbl[3] = '{sx: 4, sl: 4, x: '0, b: '0, w: '0, h: '0};
    for (int i = 0; i < 4; i++) begin
      tbl[3].x[i] = 16'($urandom);
      tbl[3].b[i] = 16'($urandom);
    end
    for (int i = 0; i < 16; i++) tbl[3].w[i] = 16'($urandom);
    for (int l = 0; l < 4; l++) tbl[3].h[l] = model_h(tbl[3], l);

    // reset held with START and strobes active must still leave everything cleared
    dif.start       = 1'b1;
    dif.size_x_in   = 4'd2;
    dif.size_l_in   = 4'd1;
    dif.x_in_enable = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("reset_h_out", 32'(dif.h_out), 0);
    check("reset_h_out_enable", 32'(dif.h_out_enable), 0);
    check("reset_ready", 32'(dif.ready), 0);
    idle_inputs();
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(tbl[i], 1'b0);

    // zero SIZE_X: READY the cycle after START, later strobes ignored
    mon_en        = 1'b0;
    dif.size_x_in = 4'd0;
    dif.size_l_in = 4'd3;
    dif.start     = 1'b1;
    tick();
    dif.start = 1'b0;
    @(negedge clk);
    check("zero_size_ready", 32'(dif.ready), 1);
    check("zero_size_h_out_enable", 32'(dif.h_out_enable), 0);
    dif.b_in_enable = 1'b1;
    dif.w_in_enable = 1'b1;
    dif.b_in        = 16'd7;
    dif.w_in        = 16'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      check("zero_size_no_ready", 32'(dif.ready), 0);
      check("zero_size_no_h_out", 32'(dif.h_out_enable), 0);
      check("zero_size_h_out_hold", 32'(dif.h_out), 32'(tbl[3].h[3]));
    end
    idle_inputs();
    tick();
    mon_en = 1'b1;
    run_vec(tbl[0], 1'b0);

    // reset in the middle of ACCUMULATE
    mon_en        = 1'b0;
    dif.size_x_in = 4'd3;
    dif.size_l_in = 4'd2;
    dif.start     = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dif.x_in_enable = 1'b1;
      dif.x_in        = tbl[1].x[i];
      tick();
    end
    dif.x_in_enable = 1'b0;
    dif.b_in_enable = 1'b1;
    dif.b_in        = 16'd0;
    tick();
    dif.b_in_enable = 1'b0;
    dif.w_in_enable = 1'b1;
    dif.w_in        = 16'd1;
    tick();
    dif.w_in_enable = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_reset_h_out", 32'(dif.h_out), 0);
    check("mid_reset_h_out_enable", 32'(dif.h_out_enable), 0);
    check("mid_reset_ready", 32'(dif.ready), 0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("after_reset_ready", 32'(dif.ready), 0);
    mon_en = 1'b1;

    run_vec(tbl[1], 1'b1);
    run_vec(tbl[3], 1'b1);
    run_vec(tbl[2], 1'b1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/model_linear_controller_engine.md
MODEL_LINEAR_CONTROLLER_ENGINE -- requirements
Module: model_linear_controller_engine

Interface
REQ-001 Parameter DATA_SIZE, default 16: element width; signed two's complement.
REQ-002 Parameter CONTROL_SIZE, default 4: width of the size inputs; the x buffer depth is 2**CONTROL_SIZE.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 START  in  1  starts a run; sampled only in IDLE.
REQ-006 SIZE_X_IN  in  CONTROL_SIZE  input vector length; sampled at accepted START.
REQ-007 SIZE_L_IN  in  CONTROL_SIZE  output vector length; sampled at accepted START.
REQ-008 X_IN_ENABLE / X_IN  in  1 / DATA_SIZE  x element strobe / value.
REQ-009 B_IN_ENABLE / B_IN  in  1 / DATA_SIZE  bias element strobe / value.
REQ-010 W_IN_ENABLE / W_IN  in  1 / DATA_SIZE  weight element strobe / value, row-major.
REQ-011 H_OUT_ENABLE / H_OUT  out  1 / DATA_SIZE  result element strobe / value.
REQ-012 READY  out  1  single-cycle pulse at end of run.

Function
REQ-013 Computes h[l] = b[l] + sum over x of W[l][x]*x[x], for l = 0..SIZE_L-1 and x = 0..SIZE_X-1.
REQ-014 Arithmetic is modulo 2**DATA_SIZE:
- product truncated to its low DATA_SIZE bits;
- accumulate wraps; no saturation.
REQ-015 FSM states:
- IDLE -> LOAD_X on START;
- LOAD_X -> LOAD_B after SIZE_X x elements;
- LOAD_B -> ACCUMULATE on one bias element;
- ACCUMULATE -> EMIT after SIZE_X weights;
- EMIT -> LOAD_B if rows remain, else IDLE.
REQ-016 Every cycle with the enable of the current state high consumes exactly one element. Gaps, including multi-cycle gaps, stall the FSM without changing the result.
REQ-017 Enables not matching the current state are ignored. With simultaneous enables, only the state-relevant stream is consumed.
REQ-018 The x buffer is written at index 0..SIZE_X-1 in LOAD_X and is reused, unchanged, for every row.
REQ-019 EMIT timing:
- EMIT lasts one cycle, the cycle after the last weight of a row is accepted;
- H_OUT_ENABLE=1 in that cycle, with H_OUT = row result;
- H_OUT holds its value until the next EMIT.
REQ-020 READY=1 in the same cycle as the last row's H_OUT_ENABLE.
REQ-021 Zero size:
- if SIZE_X_IN=0 or SIZE_L_IN=0, READY pulses the cycle after START;
- no inputs are consumed and H_OUT_ENABLE is never asserted.
REQ-022 START outside IDLE is ignored; the sizes are not resampled.
REQ-023 Row and column counters count from 0 to SIZE-1; each clears at its terminal count, with no wrap into the next run.

Reset
REQ-024 RST=1 forces:
- state IDLE;
- counters and accumulator to 0;
- H_OUT=0, H_OUT_ENABLE=0, READY=0.
REQ-025 RST takes precedence over START and all enables in the same cycle.
REQ-026 RST mid-run aborts the run with no READY pulse. Buffer contents are don't-care; the next run depends on nothing from the aborted one.

Structure
REQ-027 Shared linear-controller package:
- DATA_SIZE, CONTROL_SIZE and the ZERO/ONE control constants;
- the FSM state encoding as named constants.
REQ-028 One sub-module, model_linear_controller_mac: combinational truncated multiply-add, acc + w*x, DATA_SIZE wide.
REQ-029 The x buffer is a register array inside the engine; no memory macro is used.

Verification
REQ-030 Single row. DATA_SIZE=16, SIZE_X=2, SIZE_L=1, x=(3,4), b=5, W=(1,2) -> H_OUT=16 with H_OUT_ENABLE and READY in the same cycle.
REQ-031 Two rows, negative weights. SIZE_X=3, SIZE_L=2, x=(1,2,3), b=(0,10), W=((1,1,1),(2,0,-1)) -> H_OUT=6, then H_OUT=9 with READY.
REQ-032 Wrap-around. SIZE_X=1, SIZE_L=1, x=0x4000, W=4, b=1 -> H_OUT=0x0001.
REQ-033 Zero size and ignored START.
- SIZE_X=0, SIZE_L=3 -> READY the cycle after START, no H_OUT_ENABLE, bias/weight strobes ignored.
- A second START during a run is ignored.
REQ-034 Reset and stall recovery.
- RST asserted in the middle of ACCUMULATE -> all outputs 0 next cycle, no READY.
- Rerun of the REQ-031 case with random enable gaps -> identical outputs.
